// File: rtl/cdu_pkg.sv
// Shared types and defaults for the CDU read-counter slice.
package cdu_pkg;

  localparam int CDU_CNT_W    = 16;
  localparam int CDU_STEP_DIV = 64;
  localparam int CDU_PEND_W   = 4;

  typedef logic signed [CDU_PEND_W-1:0] pend_t;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DN   = 2'd2
  } step_e;

endpackage

// File: rtl/cdu_read_counter_if.sv
// AGC pulse-request handshake: the counter raises PCDU/MCDU requests,
// the AGC answers with one-cycle acknowledges.
interface cdu_read_counter_if;

  logic agc_ack;
  logic pcdu_req;
  logic mcdu_req;

  modport master (
    output pcdu_req,
    output mcdu_req,
    input  agc_ack
  );

  modport slave (
    input  pcdu_req,
    input  mcdu_req,
    output agc_ack
  );

endinterface

// File: rtl/cdu_pulse_queue.sv
// Signed pending-pulse accumulator between the angle counter and the AGC.
// Steps push +/-1, acknowledges pull one toward zero; the requests are
// decoded straight from the pending register.
module cdu_pulse_queue
  import cdu_pkg::*;
#(
  parameter int PEND_W = CDU_PEND_W
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clr,
  input  step_e step,
  input  logic  agc_ack,
  output logic  up_full,
  output logic  dn_full,
  output logic  pcdu_req,
  output logic  mcdu_req
);

  localparam logic signed [PEND_W-1:0] P_MAX = {1'b0, {(PEND_W-1){1'b1}}};
  localparam logic signed [PEND_W-1:0] P_MIN = {1'b1, {(PEND_W-1){1'b0}}};
  localparam logic signed [PEND_W-1:0] P_ONE = {{(PEND_W-1){1'b0}}, 1'b1};

  logic signed [PEND_W-1:0] pend_q;
  logic signed [PEND_W-1:0] pend_d;
  logic signed [PEND_W-1:0] step_delta;
  logic signed [PEND_W-1:0] ack_delta;

  assign up_full  = (pend_q == P_MAX);
  assign dn_full  = (pend_q == P_MIN);
  assign pcdu_req = ~pend_q[PEND_W-1] & (|pend_q);
  assign mcdu_req = pend_q[PEND_W-1];

  // Net pending change: step contribution plus acknowledge contribution.
  always_comb begin
    step_delta = '0;
    ack_delta  = '0;
    case (step)
      STEP_UP: if (!up_full) step_delta = P_ONE;
      STEP_DN: if (!dn_full) step_delta = -P_ONE;
      default: step_delta = '0;
    endcase
    if (agc_ack && pcdu_req)      ack_delta = -P_ONE;
    else if (agc_ack && mcdu_req) ack_delta = P_ONE;
    pend_d = pend_q + step_delta + ack_delta;
    if (clr) pend_d = '0;
  end

  // Pending register; reset discards every owed pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

endmodule

// File: rtl/cdu_read_counter.sv
// CDU angle read counter: integrates lead/lag decisions into a wrapping
// angle count under a step-rate limit, drives the active-low quadrant bits
// and mirrors every step to the AGC through cdu_pulse_queue.
// Optional feature: READ_CNT_ZERO_EN adds the synchronous zero_n clear.
module cdu_read_counter
  import cdu_pkg::*;
#(
  parameter int WIDTH    = CDU_CNT_W,
  parameter int STEP_DIV = CDU_STEP_DIV,
  parameter int PEND_W   = CDU_PEND_W
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef READ_CNT_ZERO_EN
  input  logic               zero_n,
`endif
  input  logic               lead,
  input  logic               lag,
  cdu_read_counter_if.master agc,
  output logic [WIDTH-1:0]   cnt_o,
  output logic               _D5,
  output logic               _D6,
  output logic               _D7,
  output logic               _D8
);

  localparam int TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(STEP_DIV - 1);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [TW-1:0]    timer_q;
  logic [TW-1:0]    timer_d;
  logic             zero_clr;
  logic             up_full;
  logic             dn_full;
  logic [3:0]       quad_n;
  step_e            step_sel;

`ifdef READ_CNT_ZERO_EN
  assign zero_clr = ~zero_n;
`else
  assign zero_clr = 1'b0;
`endif

  // Step decision: timer expired, exactly one of lead/lag, queue not saturated.
  always_comb begin
    step_sel = STEP_NONE;
    if (!zero_clr && (timer_q == '0)) begin
      if (lead && !lag && !up_full)      step_sel = STEP_UP;
      else if (lag && !lead && !dn_full) step_sel = STEP_DN;
    end
  end

  // Next count and step timer; an inhibited step leaves both untouched.
  always_comb begin
    cnt_d   = cnt_q;
    timer_d = timer_q;
    case (step_sel)
      STEP_UP: cnt_d = cnt_q + WIDTH'(1);
      STEP_DN: cnt_d = cnt_q - WIDTH'(1);
      default: cnt_d = cnt_q;
    endcase
    if (step_sel != STEP_NONE)  timer_d = RELOAD;
    else if (timer_q != '0)     timer_d = timer_q - TW'(1);
    if (zero_clr) begin
      cnt_d   = '0;
      timer_d = RELOAD;
    end
  end

  // Counter and timer state; timer starts at zero so the first step is free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      timer_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
    end
  end

  // Quadrant bits are the inverted top four count bits.
  for (genvar gi = 0; gi < 4; gi++) begin : g_quad
    assign quad_n[gi] = ~cnt_q[WIDTH-1-gi];
  end

  assign cnt_o = cnt_q;
  assign _D5   = quad_n[0];
  assign _D6   = quad_n[1];
  assign _D7   = quad_n[2];
  assign _D8   = quad_n[3];

  cdu_pulse_queue #(
    .PEND_W (PEND_W)
  ) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (zero_clr),
    .step     (step_sel),
    .agc_ack  (agc.agc_ack),
    .up_full  (up_full),
    .dn_full  (dn_full),
    .pcdu_req (agc.pcdu_req),
    .mcdu_req (agc.mcdu_req)
  );

endmodule

// File: doc/cdu_read_counter.md
# cdu_read_counter

Angle read counter for the CDU resolver tracking loop; sits directly upstream of the quadrant selector. Integrates lead/lag decisions from the fine error detector into a 16-bit angle count and drives the active-low quadrant bits _D5.._D8 that control sine/cosine inversion. Every counter step is mirrored to the AGC as a PCDU/MCDU pulse request through a bounded pending-pulse queue with an acknowledge handshake.

## Interface
- WIDTH, 16: angle counter width; modulo 2^WIDTH.
- STEP_DIV, 64: minimum clock cycles between counter steps (step-rate limit).
- PEND_W, 4: width of the signed pending-pulse accumulator.

- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- lead  in  1  error detector: counter lags resolver; request an up step.
- lag  in  1  error detector: counter leads resolver; request a down step.
- agc_ack  in  1  AGC has taken one pulse of the currently requested sign.
- zero_n  in  1  synchronous counter-zero command, active-low (only with READ_CNT_ZERO_EN).
- cnt_o  out  WIDTH  current angle count.
- _D5, _D6, _D7, _D8  out  1 each  active-low quadrant bits: ~cnt_o[WIDTH-1], ~cnt_o[WIDTH-2], ~cnt_o[WIDTH-3], ~cnt_o[WIDTH-4].
- pcdu_req  out  1  pending count positive; the AGC owes positive pulses.
- mcdu_req  out  1  pending count negative; the AGC owes negative pulses.

## Operation
- Reset: cnt_o=0, _D5.._D8=1, pending=0, pcdu_req=mcdu_req=0, step timer=0 (first step permitted immediately).
- Step timer: counts down to 0 and holds there. A step is taken on a cycle with timer==0 and exactly one of lead/lag high. After a step, the timer reloads STEP_DIV-1.
- lead&lag both high, or both low: no step; the timer holds at 0.
- Up step: cnt+1 and pending+1. Down step: cnt-1 and pending-1. The counter wraps both ways (0xFFFF+1 -> 0, 0-1 -> 0xFFFF).
- Saturation: pending at +(2^(PEND_W-1)-1) inhibits up steps, and pending at -(2^(PEND_W-1)) inhibits down steps. When a step is inhibited, the counter does not move and the timer does not reload. The counter and the AGC therefore never diverge.
- Handshake: pcdu_req = (pending>0) and mcdu_req = (pending<0), both decoded from the pending register. They are never high together.
- agc_ack with a request high moves pending one toward zero. agc_ack with no request high is ignored.
- A step and an ack in the same cycle both apply; the net pending change is the sum.
- A step in the direction opposite to the current pending sign is legal and reduces the magnitude of pending.

## Timing
- lead/lag/agc_ack are sampled at the rising edge of clk. cnt_o, pending, and _D bits update at that same edge.
- Requests follow the pending register with no combinational path from the inputs. Step-to-request latency is 1 cycle.
- Maximum step rate is one per STEP_DIV cycles. Maximum ack rate is one per cycle.
- Asynchronous reset mid-operation discards all pending pulses. Outputs go to their reset values immediately.

## Configuration
- READ_CNT_ZERO_EN defined: the zero_n port exists.
  - While zero_n=0: cnt->0, pending->0, timer->STEP_DIV-1, steps blocked, acks ignored.
  - Requests drop 1 cycle after zero_n falls.
- READ_CNT_ZERO_EN undefined: the zero_n port and its logic are absent. The counter is cleared only by rst_n.

## Structure
- Shared package cdu_pkg:
  - CDU_CNT_W=16
  - CDU_STEP_DIV=64
  - CDU_PEND_W=4
  - typedef pend_t (signed [CDU_PEND_W-1:0])
  - enum step_e {STEP_NONE, STEP_UP, STEP_DN}
- One sub-module, cdu_pulse_queue, holds the pending accumulator, saturation flags, and the req/ack decode.
  - Inputs: step_e and agc_ack.
  - Outputs: up_full, dn_full, pcdu_req, mcdu_req.

## Test plan
- Reset -> cnt_o=0, _D5.._D8=1111, pcdu_req=mcdu_req=0.
- lead held 200 cycles, no ack, defaults -> steps at cycles 0/64/128/192; cnt_o=4, pcdu_req=1, mcdu_req=0.
- lead held 12 steps' worth, no ack -> cnt_o stops at 7 with pending=+7; then one ack -> the next step is permitted and cnt_o=8.
- From reset, one lag step -> cnt_o=0xFFFF, _D5.._D8=0000, mcdu_req=1; one ack -> mcdu_req=0 next cycle.
- pending=+1, up step and agc_ack in the same cycle -> pending stays +1, pcdu_req stays 1, cnt_o increments.
- READ_CNT_ZERO_EN, pending=+3 and cnt_o=3, zero_n low 1 cycle -> cnt_o=0, pcdu_req=0 next cycle, next step no earlier than 63 cycles after zero_n rises.
